reg_bank_load_ctrl: RTL and testbench

//  Load sequencer for a bank of enable-gated data registers (weights/biases of the Simple GAN layers).

---
 rtl/reg_load_pkg.sv | 24 ++
 rtl/reg_en_decoder.sv | 31 +++
 rtl/reg_bank_load_ctrl.sv | 126 ++++++++++++
 tb/tb_reg_bank_load_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_load_pkg.sv
// reg_load_pkg: shared definitions for the bank load sequencer.
//   - ld_state_e  : controller state encoding (IDLE, LOAD, FULL, ERR)
//   - onehot_idx  : bit 'pos' of the one-hot decode of 'idx'
//   - *_DEF       : default widths/limits used by reg_bank_load_ctrl
package reg_load_pkg;

  localparam int XWIDTH_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;
  localparam int TIMEOUT_DEF  = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2,
    ERR  = 2'd3
  } ld_state_e;

  // Per-bit form so callers can decode any bank size without slicing a
  // fixed-width vector.
  function automatic logic onehot_idx(input int idx, input int pos);
    return idx == pos;
  endfunction

endpackage

// File: rtl/reg_en_decoder.sv
// reg_en_decoder: registered index -> one-hot write-enable decoder.
//   clk, reset_n : clock, asynchronous active-low reset
//   idx          : register index to enable
//   strobe       : write this cycle; when low the registered enable is 0
//   en           : one-hot enable, valid the cycle after strobe
module reg_en_decoder
  import reg_load_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_W-1:0]    idx,
  input  logic                strobe,
  output logic [NUM_REGS-1:0] en
);

  logic [NUM_REGS-1:0] en_nxt;

  always_comb begin
    en_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      en_nxt[i] = strobe && onehot_idx(int'(idx), i);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) en <= '0;
    else          en <= en_nxt;

endmodule

// File: rtl/reg_bank_load_ctrl.sv
// reg_bank_load_ctrl: streams valid/ready words into a bank of enable-gated
// registers, one register per accepted word, starting at start_idx and
// wrapping at the end of the bank. Raises bank_valid once the span is
// written and holds it until bank_ack.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start/start_idx/load_len : load request (sampled in IDLE; len 0 = whole bank)
//   in_valid/in_data/in_ready: input word stream
//   reg_en/reg_data     : one-hot write enable + shared data to the bank
//   bank_valid/bank_ack : span-complete flag and consumer release
//   busy                : controller not idle
//   err                 : load stalled past TIMEOUT_CYCLES
// Optional feature: define REG_LOAD_TIMEOUT_EN to enable the stall timer and
// ERR state; without it err is tied low and LOAD waits indefinitely.
module reg_bank_load_ctrl
  import reg_load_pkg::*;
#(
  parameter int XWIDTH         = XWIDTH_DEF,
  parameter int NUM_REGS       = NUM_REGS_DEF,
  parameter int IDX_W          = $clog2(NUM_REGS),
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [IDX_W-1:0]    start_idx,
  input  logic [IDX_W:0]      load_len,
  input  logic                in_valid,
  input  logic [XWIDTH-1:0]   in_data,
  output logic                in_ready,
  output logic [NUM_REGS-1:0] reg_en,
  output logic [XWIDTH-1:0]   reg_data,
  output logic                bank_valid,
  input  logic                bank_ack,
  output logic                busy,
  output logic                err
);

  localparam logic [IDX_W:0]   LEN_MAX  = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  ld_state_e        state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   remaining;
  logic [IDX_W:0]   len_eff;
  logic             accept;
  logic             load_go;

  // Ready comes from state only, so there is no comb path in_valid -> in_ready.
  assign in_ready = (state == LOAD);
  assign accept   = in_valid & in_ready;
  assign busy     = (state != IDLE);
  assign len_eff  = (load_len == '0 || load_len > LEN_MAX) ? LEN_MAX : load_len;

`ifdef REG_LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] timer;
  logic          timeout;

  assign load_go = start && (state == IDLE || state == ERR);
  assign timeout = (state == LOAD) && !accept && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign err     = (state == ERR);

  // Counts consecutive LOAD cycles without an accepted word.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)                               timer <= '0;
    else if (load_go || accept || state != LOAD) timer <= '0;
    else                                        timer <= timer + 1'b1;
`else
  assign load_go = start && (state == IDLE);
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load_go) state_nxt = LOAD;
      LOAD: begin
        if (accept && remaining == (IDX_W+1)'(1)) state_nxt = FULL;
`ifdef REG_LOAD_TIMEOUT_EN
        else if (timeout)                         state_nxt = ERR;
`endif
      end
      FULL: if (bank_ack) state_nxt = IDLE;
`ifdef REG_LOAD_TIMEOUT_EN
      ERR:  if (load_go) state_nxt = LOAD;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // bank_valid lags FULL entry by one cycle so it never overlaps the final
  // enable pulse; ack drops it together with the return to IDLE.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx        <= '0;
      remaining  <= '0;
      reg_data   <= '0;
      bank_valid <= 1'b0;
    end else begin
      bank_valid <= (state == FULL) && !bank_ack;
      if (load_go) begin
        idx       <= start_idx;
        remaining <= len_eff;
      end else if (accept) begin
        idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        remaining <= remaining - 1'b1;
        reg_data  <= in_data;
      end
    end

  reg_en_decoder #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_dec (
    .clk     (clk),
    .reset_n (reset_n),
    .idx     (idx),
    .strobe  (accept),
    .en      (reg_en)
  );

endmodule

// File: tb/tb_reg_bank_load_ctrl.sv
// Directed bench for reg_bank_load_ctrl (NUM_REGS=16, XWIDTH=32,
// TIMEOUT_CYCLES=8). Inputs change 1 ns after a rising edge; outputs are
// checked at that same point, so each check sees the state set by the edge.
module tb_reg_bank_load_ctrl;
  localparam int NR = 16;
  localparam int XW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] start_idx = '0;
  logic [IW:0]   load_len = '0;
  logic          in_valid = 1'b0;
  logic [XW-1:0] in_data = '0;
  logic          in_ready;
  logic [NR-1:0] reg_en;
  logic [XW-1:0] reg_data;
  logic          bank_valid;
  logic          bank_ack = 1'b0;
  logic          busy;
  logic          err;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  reg_bank_load_ctrl #(
    .XWIDTH(XW), .NUM_REGS(NR), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_idx(start_idx),
    .load_len(load_len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reg_en(reg_en), .reg_data(reg_data),
    .bank_valid(bank_valid), .bank_ack(bank_ack), .busy(busy), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One accepted word: enable pulse and data appear right after the edge.
  task automatic feed(input string tag, input logic [31:0] d, input logic [15:0] en_exp);
    in_valid = 1'b1;
    in_data  = d;
    step();
    chk({tag, "_en"}, 32'(reg_en), 32'(en_exp));
    chk({tag, "_data"}, reg_data, d);
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_rdy"}, 32'(in_ready), 0);
    chk({tag, "_en"}, 32'(reg_en), 0);
    chk({tag, "_data"}, reg_data, 0);
    chk({tag, "_bv"}, 32'(bank_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  logic [15:0] wrap_en [4] = '{16'h4000, 16'h8000, 16'h0001, 16'h0002};

  initial begin
    // ---- reset state
    step(); step();
    idle_outputs("reset");
    reset_n = 1'b1;
    step();

    // ---- full bank load: start_idx 0, len 0 -> 16 words
    start = 1'b1; start_idx = 4'd0; load_len = 5'd0;
    step();
    start = 1'b0;
    chk("full_busy", 32'(busy), 1);
    chk("full_rdy", 32'(in_ready), 1);
    chk("full_en0", 32'(reg_en), 0);
    for (int k = 0; k < 16; k++)
      feed("full", 32'hA0 + 32'(k), 16'h0001 << k);
    in_valid = 1'b0;
    chk("full_rdy_off", 32'(in_ready), 0);
    chk("full_bv_no_overlap", 32'(bank_valid), 0);
    step();
    chk("full_en_after", 32'(reg_en), 0);
    chk("full_bv", 32'(bank_valid), 1);
    chk("full_data_hold", reg_data, 32'hAF);
    step();
    chk("full_bv_hold", 32'(bank_valid), 1);

    // ---- start + ack together in FULL: ack wins, start dropped
    start = 1'b1; bank_ack = 1'b1;
    step();
    start = 1'b0; bank_ack = 1'b0;
    chk("ackstart_bv", 32'(bank_valid), 0);
    chk("ackstart_busy", 32'(busy), 0);
    step();
    chk("ackstart_noload", 32'(busy), 0);
    chk("ackstart_rdy", 32'(in_ready), 0);

    // ---- ack in IDLE does nothing
    bank_ack = 1'b1;
    step();
    bank_ack = 1'b0;
    chk("ack_idle_busy", 32'(busy), 0);
    chk("ack_idle_bv", 32'(bank_valid), 0);

    // ---- wrap: start_idx 14, len 4, with a start pulse mid-load
    start = 1'b1; start_idx = 4'd14; load_len = 5'd4;
    step();
    start = 1'b0;
    feed("wrap0", 32'd1, wrap_en[0]);
    feed("wrap1", 32'd2, wrap_en[1]);
    in_valid = 1'b0; start = 1'b1; start_idx = 4'd3; load_len = 5'd1;
    step();
    start = 1'b0;
    chk("midstart_en", 32'(reg_en), 0);
    chk("midstart_rdy", 32'(in_ready), 1);
    feed("wrap2", 32'd3, wrap_en[2]);
    feed("wrap3", 32'd4, wrap_en[3]);
    in_valid = 1'b0;
    step();
    chk("wrap_bv", 32'(bank_valid), 1);
    bank_ack = 1'b1;
    step();
    bank_ack = 1'b0;
    chk("wrap_idle", 32'(busy), 0);

    // ---- backpressure gaps: idx 5, len 3
    start = 1'b1; start_idx = 4'd5; load_len = 5'd3;
    step();
    start = 1'b0;
    feed("bp0", 32'h11, 16'h0020);
    in_valid = 1'b0; in_data = 32'h99;
    step();
    chk("bp_gap0_en", 32'(reg_en), 0);
    chk("bp_gap0_data", reg_data, 32'h11);
    feed("bp1", 32'h22, 16'h0040);
    in_valid = 1'b0;
    step();
    chk("bp_gap1_en", 32'(reg_en), 0);
    chk("bp_gap1_rdy", 32'(in_ready), 1);
    feed("bp2", 32'h33, 16'h0080);
    in_valid = 1'b0;
    step();
    chk("bp_bv", 32'(bank_valid), 1);
    bank_ack = 1'b1;
    step();
    bank_ack = 1'b0;

    // ---- oversize length clamps to the bank size
    start = 1'b1; start_idx = 4'd0; load_len = 5'd20;
    step();
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      in_valid = 1'b1; in_data = 32'(k);
      step();
    end
    chk("clamp_rdy15", 32'(in_ready), 1);
    feed("clamp15", 32'hC15, 16'h8000);
    in_valid = 1'b0;
    chk("clamp_full", 32'(in_ready), 0);
    bank_ack = 1'b1;
    step();
    bank_ack = 1'b0;

    // ---- reset mid-load, then a clean reload
    start = 1'b1; start_idx = 4'd2; load_len = 5'd8;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 32'h40 + 32'(k);
      step();
    end
    reset_n = 1'b0;
    #1;
    idle_outputs("midreset");
    in_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    start = 1'b1; start_idx = 4'd9; load_len = 5'd2;
    step();
    start = 1'b0;
    feed("reload0", 32'h55, 16'h0200);
    feed("reload1", 32'h66, 16'h0400);
    in_valid = 1'b0;
    step();
    chk("reload_bv", 32'(bank_valid), 1);
    bank_ack = 1'b1;
    step();
    bank_ack = 1'b0;

    // ---- stall: 3 accepts then 8 idle cycles
    start = 1'b1; start_idx = 4'd0; load_len = 5'd8;
    step();
    start = 1'b0;
    feed("stall0", 32'h70, 16'h0001);
    feed("stall1", 32'h71, 16'h0002);
    feed("stall2", 32'h72, 16'h0004);
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("stall7_err", 32'(err), 0);
    step();
`ifdef REG_LOAD_TIMEOUT_EN
    chk("timeout_err", 32'(err), 1);
    chk("timeout_rdy", 32'(in_ready), 0);
    chk("timeout_bv", 32'(bank_valid), 0);
    start = 1'b1; start_idx = 4'd4; load_len = 5'd1;
    step();
    start = 1'b0;
    chk("recover_err", 32'(err), 0);
    chk("recover_rdy", 32'(in_ready), 1);
    feed("recover", 32'h77, 16'h0010);
    in_valid = 1'b0;
    step();
    chk("recover_bv", 32'(bank_valid), 1);
`else
    chk("nto_err", 32'(err), 0);
    chk("nto_rdy", 32'(in_ready), 1);
    for (int k = 0; k < 20; k++) step();
    chk("nto_wait_err", 32'(err), 0);
    chk("nto_wait_busy", 32'(busy), 1);
    for (int k = 3; k < 8; k++)
      feed("nto_resume", 32'h70 + 32'(k), 16'h0001 << k);
    in_valid = 1'b0;
    step();
    chk("nto_bv", 32'(bank_valid), 1);
`endif
    bank_ack = 1'b1;
    step();
    bank_ack = 1'b0;
    chk("final_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
